// File: rtl/multi_port_mem_ctrl_pkg.sv
// Shared types and constants for the multi-port byte-bus memory controller.
//   - goal encodings (bytes per access), IO window select value
//   - FSM state encoding and the per-channel request record
package multi_port_mem_ctrl_pkg;

  localparam int          WORD_W = 32;
  localparam logic [2:0]  GOAL_B = 3'd1;
  localparam logic [2:0]  GOAL_H = 3'd2;
  localparam logic [2:0]  GOAL_W = 3'd4;
  localparam logic [1:0]  IO_SEL = 2'b11;   // addr[17:16] value of the UART window

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  typedef struct packed {
    logic              rw;
    logic [WORD_W-1:0] addr;
    logic [2:0]        goal;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Anything other than 1 or 2 bytes is handled as a full word.
  function automatic logic [2:0] norm_goal(input logic [2:0] g);
    return (g == GOAL_B || g == GOAL_H) ? g : GOAL_W;
  endfunction

endpackage

// File: rtl/multi_port_mem_ctrl_arb.sv
// Request arbiter for the memory controller.
//   clk, rst (sync, active low)
//   req  [N_CH]   : requesting channels
//   adv           : grant taken this edge; moves the round-robin pointer
//   gnt  [N_CH]   : onehot grant (zero when nobody requests)
//   gnt_idx       : index of the granted channel
// ROUND_ROBIN=1 searches from ptr upward; 0 is fixed priority, lowest index wins.
module rr_arbiter #(
  parameter int N_CH        = 2,
  parameter bit ROUND_ROBIN = 1'b1,
  localparam int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             adv,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               c;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < N_CH; k++) begin
      c = ROUND_ROBIN ? (int'(ptr) + k) % N_CH : k;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(c);
      end
    end
    gnt          = '0;
    gnt[gnt_idx] = found;
  end

  always_ff @(posedge clk) begin
    if (!rst)     ptr <= '0;
    else if (adv) ptr <= (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// N_CH-channel word-request arbiter and serialiser onto a byte-wide RAM/IO bus.
//   clk, rst (sync, active low), rdy (0 = pause), io_buffer_full, rollback
//   ch_req/ch_rw/ch_addr/ch_goal/ch_wdata : flat per-channel request fields
//   ch_ready (onehot done pulse), rdata (little-endian, zero-extended)
//   mem_din/mem_dout/mem_a/mem_wr : byte bus; read data arrives one cycle after address
module multi_port_mem_ctrl
  import multi_port_mem_ctrl_pkg::*;
#(
  parameter int              N_CH          = 2,
  parameter bit              ROUND_ROBIN   = 1'b1,
  parameter logic [N_CH-1:0] ROLLBACK_MASK = N_CH'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               io_buffer_full,
  input  logic               rollback,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH-1:0]    ch_rw,
  input  logic [N_CH*32-1:0] ch_addr,
  input  logic [N_CH*3-1:0]  ch_goal,
  input  logic [N_CH*32-1:0] ch_wdata,
  output logic [N_CH-1:0]    ch_ready,
  output logic [31:0]        rdata,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [31:0]        mem_a,
  output logic               mem_wr
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  req_t ch [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch[gi] = '{rw:    ch_rw[gi],
                        addr:  ch_addr[32*gi +: 32],
                        goal:  ch_goal[3*gi +: 3],
                        wdata: ch_wdata[32*gi +: 32]};
    end
  endgenerate

  state_t           state, state_n;
  req_t             cur;
  logic [IDX_W-1:0] gidx;
  logic [2:0]       idx;       // next byte to issue
  logic             pend;      // a read byte is on mem_din this cycle
  logic [1:0]       pidx;      // which byte that is
  logic             got_all;   // last byte captured while paused
  logic [31:0]      rbuf, rd_word;
  logic [2:0]       last;

  logic             grant, fin, abort, issue_wr, is_io;
  logic [N_CH-1:0]  arb_req, arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  // A rollback pulse keeps flushable channels from being granted on that edge.
  assign arb_req = ch_req & ~(rollback ? ROLLBACK_MASK : '0);

  rr_arbiter #(.N_CH(N_CH), .ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .adv     (grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign last  = cur.goal - 3'd1;
  assign is_io = (cur.addr[17:16] == IO_SEL);

  // Read word including the byte landing on mem_din this cycle.
  always_comb begin
    rd_word = rbuf;
    if (pend) rd_word[{pidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    issue_wr = 1'b0;
    case (state)
      IDLE: if (rdy && |arb_gnt) begin
        grant   = 1'b1;
        state_n = ch[arb_idx].rw ? WR : RD;
      end
      RD: begin
        // Completion beats a same-edge rollback.
        if (rdy && (got_all || (pend && {1'b0, pidx} == last))) begin
          fin     = 1'b1;
          state_n = IDLE;
        end else if (rollback && ROLLBACK_MASK[gidx]) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      WR: if (rdy && cur.rw && !(is_io && io_buffer_full)) begin
        issue_wr = 1'b1;
        if (idx == last) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cur      <= '0;
      gidx     <= '0;
      idx      <= '0;
      pend     <= 1'b0;
      pidx     <= '0;
      got_all  <= 1'b0;
      rbuf     <= '0;
      ch_ready <= '0;
      rdata    <= '0;
    end else begin
      ch_ready <= '0;
      state    <= state_n;
      if (grant) begin
        cur      <= ch[arb_idx];
        cur.goal <= norm_goal(ch[arb_idx].goal);
        gidx     <= arb_idx;
        idx      <= '0;
        pend     <= 1'b0;
        got_all  <= 1'b0;
        rbuf     <= '0;
      end
      if (state == RD) begin
        // An in-flight byte is captured even while paused.
        if (pend) begin
          rbuf <= rd_word;
          if (!rdy && {1'b0, pidx} == last) got_all <= 1'b1;
        end
        pend <= rdy && (idx < cur.goal) && !abort && !fin;
        pidx <= idx[1:0];
        if (rdy && idx < cur.goal) idx <= idx + 3'd1;
      end
      if (issue_wr) idx <= idx + 3'd1;
      if (fin) begin
        ch_ready[gidx] <= 1'b1;
        if (state == RD) rdata <= rd_word;
      end
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = issue_wr;
    if ((state == RD && idx < cur.goal) || state == WR)
      mem_a = cur.addr + 32'(idx);
    if (state == WR)
      mem_dout = cur.wdata[{idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
module tb_multi_port_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, rollback;
  logic [1:0]  ch_req, ch_rw;
  logic [63:0] ch_addr, ch_wdata;
  logic [5:0]  ch_goal;

  logic [1:0]  ready_rr, ready_fp;
  logic [31:0] rdata_rr, rdata_fp, a_rr, a_fp;
  logic [7:0]  din_rr, din_fp, dout_rr, dout_fp;
  logic        wr_rr, wr_fp;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [39:0] wlog[$];

  always #5 clk = ~clk;

  multi_port_mem_ctrl #(.N_CH(2), .ROUND_ROBIN(1'b1), .ROLLBACK_MASK(2'b01)) u_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .rollback(rollback),
    .ch_req(ch_req), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_goal(ch_goal), .ch_wdata(ch_wdata),
    .ch_ready(ready_rr), .rdata(rdata_rr), .mem_din(din_rr), .mem_dout(dout_rr),
    .mem_a(a_rr), .mem_wr(wr_rr));

  multi_port_mem_ctrl #(.N_CH(2), .ROUND_ROBIN(1'b0), .ROLLBACK_MASK(2'b01)) u_fp (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .rollback(rollback),
    .ch_req(ch_req), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_goal(ch_goal), .ch_wdata(ch_wdata),
    .ch_ready(ready_fp), .rdata(rdata_fp), .mem_din(din_fp), .mem_dout(dout_fp),
    .mem_a(a_fp), .mem_wr(wr_fp));

  // RAM model: byte at a is (a[3:0]+1)*0x11, so 0x100.. reads 11,22,33,44.
  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [7:0] t;
    t = {4'h0, a[3:0]} + 8'd1;
    return t * 8'h11;
  endfunction

  always @(posedge clk) begin
    din_rr <= rd_byte(a_rr);
    din_fp <= rd_byte(a_fp);
  end

  always @(negedge clk) if (wr_rr) wlog.push_back({a_rr, dout_rr});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input bit rw, input logic [31:0] addr,
                        input logic [2:0] goal, input logic [31:0] wd);
    ch_rw[ch]          = rw;
    ch_addr[32*ch +: 32] = addr;
    ch_goal[3*ch +: 3]   = goal;
    ch_wdata[32*ch +: 32] = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its done pulse; lat = edges until ch_ready is seen.
  task automatic run_txn(input int ch, input bit rw, input logic [31:0] addr,
                         input logic [2:0] goal, input logic [31:0] wd,
                         output int lat, output logic [1:0] who, output logic [31:0] rd);
    set_ch(ch, rw, addr, goal, wd);
    ch_req[ch] = 1'b1;
    lat = -1; who = '0; rd = '0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (ready_rr != 2'b00) begin
        lat = n; who = ready_rr; rd = rdata_rr;
        break;
      end
    end
    ch_req[ch] = 1'b0;
    tick;
  endtask

  typedef struct {
    string       nm;
    int          ch;
    bit          rw;
    logic [31:0] addr;
    logic [2:0]  goal;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          nb;
  } vec_t;

  vec_t tv[10];

  initial begin
    int          lat;
    logic [1:0]  who;
    logic [31:0] rd;
    int          nrr, nfp, blocked;
    int          grr[4], gfp[4];
    bit          saw;

    tv[0] = '{"rd_w_ch1",   1, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211, 6, 0};
    tv[1] = '{"rd_b",       0, 1'b0, 32'h0000_0105, 3'd1, 32'h0,         32'h0000_0066, 3, 0};
    tv[2] = '{"rd_h_carry", 0, 1'b0, 32'h0000_010E, 3'd2, 32'h0,         32'h0000_10FF, 4, 0};
    tv[3] = '{"rd_goal3",   1, 1'b0, 32'h0000_0200, 3'd3, 32'h0,         32'h4433_2211, 6, 0};
    tv[4] = '{"rd_wrap",    0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_1110, 4, 0};
    tv[5] = '{"wr_w",       0, 1'b1, 32'h0000_0300, 3'd4, 32'hDEAD_BEEF, 32'h0,         5, 4};
    tv[6] = '{"wr_h_wrap",  1, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_1234, 32'h0,         3, 2};
    tv[7] = '{"wr_io_free", 0, 1'b1, 32'h0003_0000, 3'd1, 32'hCAFE_0041, 32'h0,         2, 1};
    tv[8] = '{"rd_h",       1, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h0000_2211, 4, 0};
    tv[9] = '{"wr_goal0",   0, 1'b1, 32'h0000_0600, 3'd0, 32'h0403_0201, 32'h0,         5, 4};

    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; rollback = 1'b0;
    ch_req = '0; ch_rw = '0; ch_addr = '0; ch_goal = '0; ch_wdata = '0;
    repeat (2) tick;
    chk("rst_ready", 32'(ready_rr), 32'h0);
    chk("rst_rdata", rdata_rr, 32'h0);
    chk("rst_mem_a", a_rr, 32'h0);
    chk("rst_mem_wr", 32'(wr_rr), 32'h0);
    chk("rst_mem_dout", 32'(dout_rr), 32'h0);
    rst = 1'b1;
    tick;

    // Arbitration: both channels request continuously.
    set_ch(0, 1'b0, 32'h100, 3'd1, 32'h0);
    set_ch(1, 1'b0, 32'h104, 3'd1, 32'h0);
    nrr = 0; nfp = 0;
    for (int i = 0; i < 4; i++) begin grr[i] = -1; gfp[i] = -1; end
    ch_req = 2'b11;
    for (int c = 0; c < 40 && (nrr < 4 || nfp < 4); c++) begin
      tick;
      if (ready_rr != 2'b00 && nrr < 4) begin grr[nrr] = int'(ready_rr[1]); nrr++; end
      if (ready_fp != 2'b00 && nfp < 4) begin gfp[nfp] = int'(ready_fp[1]); nfp++; end
      if (nrr >= 4 && nfp >= 4) ch_req = 2'b00;
    end
    ch_req = 2'b00;
    repeat (3) tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(grr[i]), 32'(i % 2));
      chk($sformatf("fp_grant%0d", i), 32'(gfp[i]), 32'h0);
    end

    // Directed single-transaction table.
    for (int v = 0; v < 10; v++) begin
      wlog.delete();
      run_txn(tv[v].ch, tv[v].rw, tv[v].addr, tv[v].goal, tv[v].wdata, lat, who, rd);
      chk({tv[v].nm, "_lat"}, 32'(lat), 32'(tv[v].exp_lat));
      chk({tv[v].nm, "_who"}, 32'(who), 32'(1 << tv[v].ch));
      if (!tv[v].rw) chk({tv[v].nm, "_rdata"}, rd, tv[v].exp_rd);
      else begin
        chk({tv[v].nm, "_nbytes"}, 32'(wlog.size()), 32'(tv[v].nb));
        for (int k = 0; k < tv[v].nb && k < wlog.size(); k++)
          chk($sformatf("%s_byte%0d", tv[v].nm, k), 32'(wlog[k]),
              32'({tv[v].addr + 32'(k), tv[v].wdata[8*k +: 8]}));
      end
    end

    // IO write held off by a full UART buffer for 3 cycles.
    set_ch(1, 1'b1, 32'h0003_0000, 3'd1, 32'h41);
    io_buffer_full = 1'b1;
    ch_req[1] = 1'b1;
    blocked = 0;
    for (int n = 1; n <= 3; n++) begin
      tick;
      if (!wr_rr) blocked++;
    end
    chk("io_blocked_cycles", 32'(blocked), 32'd3);
    tick;
    io_buffer_full = 1'b0;
    #1;
    chk("io_mem_wr", 32'(wr_rr), 32'h1);
    chk("io_mem_dout", 32'(dout_rr), 32'h41);
    chk("io_mem_a", a_rr, 32'h0003_0000);
    tick;
    chk("io_ready", 32'(ready_rr), 32'h2);
    ch_req = 2'b00;
    tick;

    // Rollback aborts a ch0 read.
    set_ch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    ch_req = 2'b01;
    tick;                           // after E0
    tick;                           // after E1
    rollback = 1'b1; ch_req = 2'b00;
    tick;                           // after E2
    rollback = 1'b0;
    chk("rb_rd_mem_a", a_rr, 32'h0);
    saw = 1'b0;
    for (int n = 0; n < 8; n++) begin tick; if (ready_rr != 2'b00) saw = 1'b1; end
    chk("rb_rd_no_ready", 32'(saw), 32'h0);

    // Rollback at a grant edge: masked ch0 skipped, ch1 served.
    set_ch(0, 1'b0, 32'h100, 3'd1, 32'h0);
    set_ch(1, 1'b0, 32'h101, 3'd1, 32'h0);
    ch_req = 2'b11; rollback = 1'b1;
    tick;
    rollback = 1'b0; ch_req[0] = 1'b0;
    who = '0; rd = '0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (ready_rr != 2'b00) begin who = ready_rr; rd = rdata_rr; break; end
    end
    ch_req = 2'b00;
    chk("rb_idle_who", 32'(who), 32'h2);
    chk("rb_idle_rdata", rd, 32'h22);
    tick;

    // Rollback never aborts a write.
    wlog.delete();
    set_ch(1, 1'b1, 32'h400, 3'd2, 32'hBEEF);
    ch_req = 2'b10;
    tick;
    rollback = 1'b1;
    tick;
    rollback = 1'b0;
    who = '0;
    for (int n = 0; n < 10; n++) begin
      if (ready_rr != 2'b00) begin who = ready_rr; break; end
      tick;
    end
    ch_req = 2'b00;
    chk("rb_wr_who", 32'(who), 32'h2);
    chk("rb_wr_nbytes", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("rb_wr_byte0", 32'(wlog[0]), 32'({32'h400, 8'hEF}));
      chk("rb_wr_byte1", 32'(wlog[1]), 32'({32'h401, 8'hBE}));
    end
    tick;

    // Two paused cycles in a goal=2 read: latency 4 -> 6, same data.
    set_ch(0, 1'b0, 32'h100, 3'd2, 32'h0);
    ch_req = 2'b01;
    lat = -1; rd = '0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (ready_rr != 2'b00) begin lat = n; rd = rdata_rr; break; end
      if (n == 2) rdy = 1'b0;
      if (n == 4) rdy = 1'b1;
    end
    rdy = 1'b1; ch_req = 2'b00;
    chk("stall_lat", 32'(lat), 32'd6);
    chk("stall_rdata", rd, 32'h2211);
    tick;

    // Reset in the middle of a word write.
    set_ch(0, 1'b1, 32'h500, 3'd4, 32'h1122_3344);
    ch_req = 2'b01;
    tick;
    chk("rstw_first_wr", 32'(wr_rr), 32'h1);
    tick;
    rst = 1'b0; ch_req = 2'b00;
    tick;
    chk("rstw_mem_wr", 32'(wr_rr), 32'h0);
    chk("rstw_mem_a", a_rr, 32'h0);
    chk("rstw_rdata", rdata_rr, 32'h0);
    rst = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 8; n++) begin tick; if (ready_rr != 2'b00 || wr_rr) saw = 1'b1; end
    chk("rstw_quiet", 32'(saw), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
